frame_write_buffer: RTL
=======================

# frame_write_buffer

Upstream feeder for `mem_manager`. Accepts 32-bit pixel words from the camera capture path at up to one word per `clk`, buffers them in a small FIFO and issues sequential write requests on the `mem_manager` request port. The block generates frame-relative DDR word addresses and holds each request stable while `mem_pause` is asserted. The camera path cannot be stalled, so overflow is detected and reported rather than back-pressured.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: buffer entries; power of two, at least 4.
- `FRAME_WORDS`, 76800: words per frame; address wrap span; 1..2^18.
- `ADDR_W`, 18: word address width; matches `mem_manager` `starting_address`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: main system clock, the same clock that drives `mem_manager` `clk`.
- `rst_n` in 1: asynchronous active-low reset.
- `base_address` in ADDR_W: frame base; sampled only when an address is generated.
- `pix_valid` in 1: pixel word present this cycle.
- `pix_sof` in 1: qualifies `pix_valid`; the word is the first of a frame.
- `pix_data` in 32: pixel word.
- `mem_pause` in 1: from `mem_manager`; the current request must be held.
- `mem_wren` out 1: write request valid; drives `mem_manager` `wren`.
- `mem_address` out ADDR_W: drives `starting_address`.
- `mem_data_write` out 32: drives `data_write`.
- `fifo_full` out 1: FIFO at `FIFO_DEPTH`.
- `fifo_level` out clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; a word was dropped.
- `overflow_clr` in 1: clears `overflow`.
- `busy` out 1: FIFO non-empty or `mem_wren` high.

## Operation
- Each FIFO entry is 33 bits: {sof, data}.
- Push condition: `pix_valid && !fifo_full`. `fifo_full` is evaluated before any same-cycle pop. If `pix_valid && fifo_full`, the word is dropped and `overflow` is set.
- The output registers (`mem_wren`, `mem_address`, `mem_data_write`) form the in-flight slot.
- Accept condition: a clock edge with `mem_wren && !mem_pause`.
- Load condition: `(!mem_wren || accept) && fifo_level != 0`.
  - On load, the FIFO head is popped into the slot and `mem_wren` goes to 1.
  - If the slot is accepted and the FIFO is empty, `mem_wren` goes to 0.
- Address generation at load:
  - sof=1: `base_address`.
  - sof=0: `last_addr + 1`. If `last_addr` equals `base_address + FRAME_WORDS - 1`, the address wraps to `base_address`.
  - First word after reset with sof=0: `base_address`.
  - All arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.
- Consecutive requests never share an address, which prevents the `mem_manager` single-word cache from suppressing a write.
- States:
  - IDLE: `mem_wren`=0. Go to ISSUE on load.
  - ISSUE: `mem_wren`=1.
    - Stay in ISSUE while `mem_pause`=1 (outputs frozen).
    - On accept: reload and stay in ISSUE if data remains, otherwise go to IDLE.
- `overflow_clr` and a same-cycle drop: set wins.
- `busy` = `mem_wren || fifo_level != 0`.

## Timing
- Reset values: `mem_wren`=0, `mem_address`=0, `mem_data_write`=0, `overflow`=0, `fifo_level`=0, `fifo_full`=0, `busy`=0. State is IDLE and `last_addr` is invalid.
- Reset asserted mid-request drops the FIFO contents and the in-flight word immediately.
- Latency: a word pushed at edge N into an empty block gives `mem_wren`=1 after edge N+1.
- Back-to-back: with `mem_pause` low, sustained throughput is one word per `clk`.
- Outputs change only at a load edge. They are stable throughout pause.
- Simultaneous push and pop at `fifo_level`=FIFO_DEPTH-1: the push is accepted and the level is unchanged.

## Configuration
- `FRAME_WRITE_BUFFER_STATS_EN` defined:
  - Adds output `drop_count` [15:0], saturating at 16'hFFFF, counting dropped words.
  - Adds output `frame_count` [15:0], wrapping, incremented on each sof load.
  - Both are cleared by reset; `drop_count` is also cleared by `overflow_clr`.
- `FRAME_WRITE_BUFFER_STATS_EN` undefined: these ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `falcon_mem_pkg`: `ADDR_W` default and the state typedef (IDLE, ISSUE).
- One sub-module `sync_fifo`:
  - Show-ahead, parameterised width and depth.
  - Provides full, empty and level outputs.
  - Asynchronous active-low reset.
- Address generation, slot registers and the state machine live in the top level.

## Test plan
- Reset, then 4 words with sof on the first, `base_address`=0x100, `mem_pause`=0 -> addresses 0x100..0x103 on 4 consecutive cycles, first `mem_wren` 2 edges after the first push.
- `mem_pause`=1 for 5 cycles during the 2nd request -> outputs frozen; no word lost or duplicated; order preserved.
- `FRAME_WORDS`=8, 10 words, sof on the first only -> the 9th word goes to `base_address`.
- `mem_pause` held high while 20 words arrive with `FIFO_DEPTH`=16 -> words 18..20 dropped (16 in FIFO, 1 in the slot) and `overflow`=1; `overflow_clr` clears it.
- sof mid-stream after 3 words -> the next load uses `base_address` regardless of `last_addr`.
- `rst_n` low during ISSUE with 5 words queued -> `mem_wren`=0 immediately and `fifo_level`=0.

Source files
------------

// File: rtl/falcon_mem_pkg.sv
// Shared definitions for the mem_manager feeder path.
//   ADDR_W_DEFAULT : DDR word address width (matches mem_manager starting_address)
//   PIX_W          : pixel word width
//   fifo_entry_t   : buffered word {sof, data}
//   wr_state_t     : write-request FSM states
package falcon_mem_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 18;
    localparam int unsigned PIX_W          = 32;
    localparam int unsigned ENTRY_W        = PIX_W + 1;

    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on rd_data_c while not empty.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   wr_en, wr_data       : push (ignored when full)
//   rd_en, rd_data_c     : pop (ignored when empty), head word
//   full, empty, level   : registered occupancy flags and count
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;
    logic [LVL_W-1:0] level_nxt;

    assign do_wr     = wr_en && !full;
    assign do_rd     = rd_en && !empty;
    assign level_nxt = level + LVL_W'(do_wr) - LVL_W'(do_rd);
    assign rd_data_c = mem[rd_ptr];

    // Pointers, level and flags; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_nxt;
            full  <= (level_nxt == LVL_W'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    // Storage array carries no reset
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/frame_write_buffer.sv
// Buffers camera pixel words and issues sequential, frame-relative write
// requests to mem_manager. The capture path cannot stall, so words arriving
// while the FIFO is full are dropped and flagged on a sticky overflow bit.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   base_address                      : frame base, sampled when an address is generated
//   pix_valid, pix_sof, pix_data      : incoming pixel word
//   mem_pause                         : hold the current request
//   mem_wren, mem_address, mem_data_write : request slot towards mem_manager
//   fifo_full, fifo_level, busy       : status
//   overflow, overflow_clr            : sticky drop flag and its clear
// Optional (FRAME_WRITE_BUFFER_STATS_EN): drop_count, frame_count.
module frame_write_buffer
    import falcon_mem_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned FRAME_WORDS = 76800,
    parameter int unsigned ADDR_W      = ADDR_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             base_address,
    input  logic                          pix_valid,
    input  logic                          pix_sof,
    input  logic [PIX_W-1:0]              pix_data,
    input  logic                          mem_pause,
    output logic                          mem_wren,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [PIX_W-1:0]              mem_data_write,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic                          busy
`ifdef FRAME_WRITE_BUFFER_STATS_EN
    ,
    output logic [15:0]                   drop_count,
    output logic [15:0]                   frame_count
`endif
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_t          state;
    fifo_entry_t        head;
    logic [ENTRY_W-1:0] head_bits;
    logic               fifo_empty;
    logic               push;
    logic               drop;
    logic               accept;
    logic               pop;
    logic               wren_next;
    logic [LVL_W-1:0]   level_next;
    logic               addr_valid;
    logic [ADDR_W-1:0]  wrap_addr;
    logic [ADDR_W-1:0]  next_addr;

    // Full is the registered flag, so a same-cycle pop never makes room
    assign push       = pix_valid && !fifo_full;
    assign drop       = pix_valid && fifo_full;
    assign accept     = mem_wren && !mem_pause;
    assign pop        = (!mem_wren || accept) && !fifo_empty;
    assign wren_next  = pop || (mem_wren && !accept);
    assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);
    assign head       = fifo_entry_t'(head_bits);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push),
        .wr_data   ({pix_sof, pix_data}),
        .rd_en     (pop),
        .rd_data_c (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Next request address; mem_address doubles as the last generated address
    always_comb begin
        wrap_addr = base_address + ADDR_W'(FRAME_WORDS - 1);
        next_addr = mem_address + ADDR_W'(1);
        if (head.sof || !addr_valid || (mem_address == wrap_addr)) begin
            next_addr = base_address;
        end
    end

    // Request slot, state machine and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mem_wren       <= 1'b0;
            mem_address    <= '0;
            mem_data_write <= '0;
            addr_valid     <= 1'b0;
            overflow       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            busy <= wren_next || (level_next != '0);

            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end

            if (pop) begin
                mem_address    <= next_addr;
                mem_data_write <= head.data;
                addr_valid     <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= ISSUE;
                        mem_wren <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (accept && !pop) begin
                        state    <= IDLE;
                        mem_wren <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_wren <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_WRITE_BUFFER_STATS_EN
    // Drop counter saturates; frame counter wraps on each start-of-frame load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count  <= '0;
            frame_count <= '0;
        end else begin
            if (drop) begin
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else if (overflow_clr) begin
                drop_count <= '0;
            end
            if (pop && head.sof) frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule
